// File: rtl/pea_core_if.sv
// Token bus between the polynomial evaluation core and its FIFOs / firing control.
// slave is the core side; master is the environment (FIFOs, enable logic).
interface pea_core_if #(
   parameter int WORD_SIZE = 16
);
   logic                   invoke;
   logic                   fc;
   logic [WORD_SIZE-1:0]   command_in;
   logic                   rd_in_command;
   logic [WORD_SIZE-1:0]   data_in;
   logic                   rd_in_data;
   logic                   wr_out_result;
   logic [2*WORD_SIZE-1:0] data_out_result;
   logic                   wr_out_status;
   logic [2*WORD_SIZE-1:0] data_out_status;

   modport slave (
      input  invoke, command_in, data_in,
      output fc, rd_in_command, rd_in_data,
             wr_out_result, data_out_result, wr_out_status, data_out_status
   );

   modport master (
      output invoke, command_in, data_in,
      input  fc, rd_in_command, rd_in_data,
             wr_out_result, data_out_result, wr_out_status, data_out_status
   );
endinterface

// File: rtl/pea_core.sv
// Polynomial evaluation core: STP/EVP/RST commands over a parametrised coefficient store, Horner datapath.
// Optional signed-overflow detection (status code 5) under `PEA_OVERFLOW_DETECT_EN; all strobes registered.
module pea_core #(
   parameter int WORD_SIZE = 16,
   parameter int NUM_VEC   = 8,
   parameter int MAX_DEG   = 10
) (
   input logic       clk,
   input logic       rst,
   pea_core_if.slave bus
);
   localparam int DW = 2 * WORD_SIZE;
   localparam int KW = (MAX_DEG > 0) ? $clog2(MAX_DEG + 1) : 1;
   localparam int AW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_RD_CMD, S_CMD_CAP, S_DECODE, S_STP_RD, S_STP_CAP,
      S_EV_RD, S_EV_CAP, S_EV_CALC, S_EV_WR, S_STATUS, S_DONE
   } state_t;

   function automatic logic [DW-1:0] sext(input logic [WORD_SIZE-1:0] w);
      return {{WORD_SIZE{w[WORD_SIZE-1]}}, w};
   endfunction

   state_t               state_q, state_d;
   logic [WORD_SIZE-1:0] cmd_q, cmd_d;
   logic [15:0]          code_q, code_d;
   logic [4:0]           cnt_q, cnt_d;
   logic [KW-1:0]        idx_q, idx_d;
   logic [DW-1:0]        x_q, x_d, acc_q, acc_d;
   logic [DW-1:0]        res_q, res_d, stat_q, stat_d;
   logic [NUM_VEC-1:0]   vld_q, vld_d;
   logic                 rd_cmd_q, rd_cmd_d, rd_dat_q, rd_dat_d, rd_dly_q;
   logic                 wr_res_q, wr_res_d, wr_stat_q, wr_stat_d, fc_q, fc_d;
   logic                 coef_we, deg_we;

   logic [WORD_SIZE-1:0] coef_q [NUM_VEC][MAX_DEG+1];
   logic [KW-1:0]        deg_q  [NUM_VEC];

   logic [7:0]           opc;
   logic [2:0]           a_fld;
   logic [4:0]           b_fld;
   logic [AW-1:0]        a_idx;
   logic [KW-1:0]        b_k, deg_a;
   logic                 a_ok, b_ok;
   logic [DW-1:0]        prod, sum, coef_cur_x;

   assign opc        = cmd_q[15:8];
   assign a_fld      = cmd_q[7:5];
   assign b_fld      = cmd_q[4:0];
   assign a_idx      = a_fld[AW-1:0];
   assign b_k        = b_fld[KW-1:0];
   assign deg_a      = deg_q[a_idx];
   assign a_ok       = int'(a_fld) < NUM_VEC;
   assign b_ok       = int'(b_fld) <= MAX_DEG;
   assign coef_cur_x = sext(coef_q[a_idx][idx_q]);
   // Low half of the product is identical for signed/unsigned operands, giving the wrap.
   assign prod       = acc_q * x_q;
   assign sum        = prod + coef_cur_x;

`ifdef PEA_OVERFLOW_DETECT_EN
   logic               ovf_q, ovf_d, step_ovf;
   logic signed [2*DW-1:0] prod_full;
   assign prod_full = $signed(acc_q) * $signed(x_q);
   assign step_ovf  = (prod_full != {{DW{prod_full[DW-1]}}, prod_full[DW-1:0]})
                    || ((prod[DW-1] == coef_cur_x[DW-1]) && (sum[DW-1] != prod[DW-1]));
`endif

   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      code_d    = code_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      x_d       = x_q;
      acc_d     = acc_q;
      vld_d     = vld_q;
      res_d     = res_q;
      stat_d    = stat_q;
      rd_cmd_d  = 1'b0;
      rd_dat_d  = 1'b0;
      wr_res_d  = 1'b0;
      wr_stat_d = 1'b0;
      fc_d      = 1'b0;
      coef_we   = 1'b0;
      deg_we    = 1'b0;
`ifdef PEA_OVERFLOW_DETECT_EN
      ovf_d     = ovf_q;
`endif
      // STP tokens arrive one cycle behind their read strobe, highest degree first.
      if (rd_dly_q && (state_q == S_STP_RD || state_q == S_STP_CAP)) begin
         coef_we = 1'b1;
         idx_d   = idx_q - 1'b1;
      end

      case (state_q)
         S_IDLE: if (bus.invoke) begin
            state_d  = S_RD_CMD;
            rd_cmd_d = 1'b1;
         end
         S_RD_CMD:  state_d = S_CMD_CAP;
         S_CMD_CAP: begin
            cmd_d   = bus.command_in;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            code_d  = 16'd0;
            state_d = S_STATUS;
`ifdef PEA_OVERFLOW_DETECT_EN
            ovf_d   = 1'b0;
`endif
            case (opc)
               8'h01: begin
                  if (!a_ok)      code_d = 16'd6;
                  else if (!b_ok) code_d = 16'd2;
                  else begin
                     cnt_d    = b_fld;
                     idx_d    = b_k;
                     rd_dat_d = 1'b1;
                     state_d  = S_STP_RD;
                  end
               end
               8'h02: begin
                  if (!a_ok)               code_d = 16'd6;
                  else if (!vld_q[a_idx])  code_d = 16'd3;
                  else if (b_fld == 5'd0)  code_d = 16'd4;
                  else begin
                     cnt_d    = b_fld;
                     rd_dat_d = 1'b1;
                     state_d  = S_EV_RD;
                  end
               end
               8'h03: begin
                  if (!a_ok) code_d = 16'd6;
                  else       vld_d[a_idx] = 1'b0;
               end
               default: code_d = 16'd1;
            endcase
         end
         S_STP_RD: begin
            if (cnt_q != 5'd0) begin
               rd_dat_d = 1'b1;
               cnt_d    = cnt_q - 5'd1;
            end else begin
               state_d = S_STP_CAP;
            end
         end
         S_STP_CAP: begin
            deg_we       = 1'b1;
            vld_d[a_idx] = 1'b1;
            state_d      = S_STATUS;
         end
         S_EV_RD: state_d = S_EV_CAP;
         S_EV_CAP: begin
            x_d   = sext(bus.data_in);
            acc_d = sext(coef_q[a_idx][deg_a]);
            idx_d = deg_a - 1'b1;
            cnt_d = cnt_q - 5'd1;
            if (deg_a == '0) begin
               res_d    = sext(coef_q[a_idx][deg_a]);
               wr_res_d = 1'b1;
               state_d  = S_EV_WR;
            end else begin
               state_d = S_EV_CALC;
            end
         end
         S_EV_CALC: begin
            acc_d = sum;
            idx_d = idx_q - 1'b1;
`ifdef PEA_OVERFLOW_DETECT_EN
            ovf_d = ovf_q | step_ovf;
`endif
            if (idx_q == '0) begin
               res_d    = sum;
               wr_res_d = 1'b1;
               state_d  = S_EV_WR;
            end
         end
         S_EV_WR: begin
            if (cnt_q != 5'd0) begin
               rd_dat_d = 1'b1;
               state_d  = S_EV_RD;
            end else begin
               state_d = S_STATUS;
`ifdef PEA_OVERFLOW_DETECT_EN
               if (ovf_q) code_d = 16'd5;
`endif
            end
         end
         S_STATUS: begin
            fc_d    = 1'b1;
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (state_d == S_STATUS && state_q != S_STATUS) begin
         wr_stat_d    = 1'b1;
         stat_d       = '0;
         stat_d[31:0] = {opc, 5'b0, a_fld, code_d};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cmd_q     <= '0;
         code_q    <= '0;
         cnt_q     <= '0;
         idx_q     <= '0;
         x_q       <= '0;
         acc_q     <= '0;
         res_q     <= '0;
         stat_q    <= '0;
         vld_q     <= '0;
         rd_cmd_q  <= 1'b0;
         rd_dat_q  <= 1'b0;
         rd_dly_q  <= 1'b0;
         wr_res_q  <= 1'b0;
         wr_stat_q <= 1'b0;
         fc_q      <= 1'b0;
`ifdef PEA_OVERFLOW_DETECT_EN
         ovf_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         code_q    <= code_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         x_q       <= x_d;
         acc_q     <= acc_d;
         res_q     <= res_d;
         stat_q    <= stat_d;
         vld_q     <= vld_d;
         rd_cmd_q  <= rd_cmd_d;
         rd_dat_q  <= rd_dat_d;
         rd_dly_q  <= rd_dat_q;
         wr_res_q  <= wr_res_d;
         wr_stat_q <= wr_stat_d;
         fc_q      <= fc_d;
`ifdef PEA_OVERFLOW_DETECT_EN
         ovf_q     <= ovf_d;
`endif
      end
   end

   // Store contents of invalid vectors are don't-care, so no reset here.
   always_ff @(posedge clk) begin
      if (coef_we) coef_q[a_idx][idx_q] <= bus.data_in;
      if (deg_we)  deg_q[a_idx] <= b_k;
   end

   assign bus.rd_in_command   = rd_cmd_q;
   assign bus.rd_in_data      = rd_dat_q;
   assign bus.wr_out_result   = wr_res_q;
   assign bus.data_out_result = res_q;
   assign bus.wr_out_status   = wr_stat_q;
   assign bus.data_out_status = stat_q;
   assign bus.fc              = fc_q;
endmodule

// File: tb/tb_pea_core.sv
// Directed bench for pea_core: FIFO models on the token bus, firings checked for status, results and strobes.
module tb_pea_core;
   logic clk;
   logic rst;

   pea_core_if #(.WORD_SIZE(16)) bus();

   pea_core #(.WORD_SIZE(16), .NUM_VEC(8), .MAX_DEG(10)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_mis = 0;
   logic [15:0] cmd_fifo [$];
   logic [15:0] dat_fifo [$];
   logic [31:0] res_seen [$];
   logic [31:0] stat_seen [$];
   int          n_rd = 0;
   int          n_fc = 0;
   int          fc_after_stat = 0;
   int          stat_pos = -1;
   logic        prev_stat = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_mis++;
         $display("FAIL %s: observed %h, expected %h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [31:0] res_at(input int i);
      return (i < res_seen.size()) ? res_seen[i] : 32'hxxxx_xxxx;
   endfunction

   // FIFO models and output monitor: sample on negedge, present new tokens just after posedge.
   initial begin
      logic pc, pd;
      bus.command_in = '0;
      bus.data_in    = '0;
      forever begin
         @(negedge clk);
         pc = bus.rd_in_command;
         pd = bus.rd_in_data;
         if (pd) n_rd++;
         if (bus.wr_out_result) res_seen.push_back(bus.data_out_result);
         if (bus.wr_out_status) begin
            stat_seen.push_back(bus.data_out_status);
            stat_pos = res_seen.size();
         end
         if (bus.fc) begin
            n_fc++;
            if (prev_stat) fc_after_stat++;
         end
         prev_stat = bus.wr_out_status;
         @(posedge clk);
         #1;
         if (pc) bus.command_in = (cmd_fifo.size() != 0) ? cmd_fifo.pop_front() : 16'h0;
         if (pd) bus.data_in    = (dat_fifo.size() != 0) ? dat_fifo.pop_front() : 16'h0;
      end
   end

   task automatic clear_mon();
      n_rd = 0; n_fc = 0; fc_after_stat = 0; stat_pos = -1;
      res_seen.delete();
      stat_seen.delete();
   endtask

   task automatic fire(input logic [15:0] cmd, input logic [15:0] code, input int nres, input int nrd);
      logic [31:0] st;
      clear_mon();
      cmd_fifo.push_back(cmd);
      @(posedge clk); #1 bus.invoke = 1'b1;
      @(posedge clk); #1 bus.invoke = 1'b0;
      @(negedge clk);
      chk("cmd_rd_latency", 32'(bus.rd_in_command), 32'd1);
      for (int i = 0; i < 400 && n_fc == 0; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      st = (stat_seen.size() != 0) ? stat_seen[0] : 32'hxxxx_xxxx;
      chk("fc_count", 32'(n_fc), 32'd1);
      chk("fc_after_status", 32'(fc_after_stat), 32'd1);
      chk("status_count", 32'(stat_seen.size()), 32'd1);
      chk("status_token", st, {cmd[15:8], 5'b0, cmd[7:5], code});
      chk("status_after_results", 32'(stat_pos), 32'(nres));
      chk("result_count", 32'(res_seen.size()), 32'(nres));
      chk("data_reads", 32'(n_rd), 32'(nrd));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst        = 1'b1;
      bus.invoke = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_strobes", 32'({bus.rd_in_command, bus.rd_in_data, bus.wr_out_result,
                               bus.wr_out_status, bus.fc}), 32'd0);
      chk("rst_result_bus", bus.data_out_result, 32'd0);
      chk("rst_status_bus", bus.data_out_status, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (2) @(posedge clk);

      // EVP A=5 on a never-stored vector
      fire(16'h02A1, 16'd3, 0, 0);

      // STP A=2: 1 2 3 -> x^2+2x+3, then EVP x=2, -1
      dat_fifo.push_back(16'd1); dat_fifo.push_back(16'd2); dat_fifo.push_back(16'd3);
      fire(16'h0142, 16'd0, 0, 3);
      dat_fifo.push_back(16'd2); dat_fifo.push_back(16'hFFFF);
      fire(16'h0242, 16'd0, 2, 2);
      chk("evp_x2", res_at(0), 32'd11);
      chk("evp_xm1", res_at(1), 32'd2);

      // degree above MAX_DEG, then EVP on that untouched vector
      fire(16'h010C, 16'd2, 0, 0);
      fire(16'h0201, 16'd3, 0, 0);

      // unknown opcode, RST of valid vector, EVP after RST
      fire(16'h7F00, 16'd1, 0, 0);
      fire(16'h0340, 16'd0, 0, 0);
      fire(16'h0241, 16'd3, 0, 0);

      // degree-0 polynomial -7, evaluated at 5; then EVP with b=0
      dat_fifo.push_back(16'hFFF9);
      fire(16'h0160, 16'd0, 0, 1);
      dat_fifo.push_back(16'd5);
      fire(16'h0261, 16'd0, 1, 1);
      chk("deg0_result", res_at(0), 32'hFFFF_FFF9);
      fire(16'h0260, 16'd4, 0, 0);

      // all-0x7FFF degree 10 at x=0x7FFF: sum x^1..x^11 mod 2^32
      for (int i = 0; i < 11; i++) dat_fifo.push_back(16'h7FFF);
      fire(16'h012A, 16'd0, 0, 11);
      dat_fifo.push_back(16'h7FFF);
`ifdef PEA_OVERFLOW_DETECT_EN
      fire(16'h0221, 16'd5, 1, 1);
`else
      fire(16'h0221, 16'd0, 1, 1);
`endif
      chk("wrap_result", res_at(0), 32'h8002_FFFF);

      // reset during EV_CALC of a 3-token EVP on A=4
      dat_fifo.push_back(16'd1); dat_fifo.push_back(16'd1); dat_fifo.push_back(16'd1);
      fire(16'h0182, 16'd0, 0, 3);
      clear_mon();
      cmd_fifo.push_back(16'h0283);
      dat_fifo.push_back(16'd1); dat_fifo.push_back(16'd2); dat_fifo.push_back(16'd3);
      @(posedge clk); #1 bus.invoke = 1'b1;
      @(posedge clk); #1 bus.invoke = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_strobes", 32'({bus.rd_in_command, bus.rd_in_data, bus.wr_out_result,
                                   bus.wr_out_status, bus.fc}), 32'd0);
      chk("rst_mid_result_bus", bus.data_out_result, 32'd0);
      repeat (10) @(posedge clk);
      chk("rst_mid_fc", 32'(n_fc), 32'd0);
      chk("rst_mid_status", 32'(stat_seen.size()), 32'd0);
      dat_fifo.delete();
      fire(16'h0281, 16'd3, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
